soc_bus_arbiter: RTL

Two-master bus arbiter and access sequencer for the soc_65xx system bus. It shares the single memory/peripheral bus between the 65xx CPU (master 0) and a DMA/loader master (master 1) using round-robin with a DMA lock option. It stretches accesses to the slow peripheral window (UART, GPIO, CIA-style timer/serial port) to the next peripheral clock-enable pulse, which it also generates. It sits between the CPU core and the address decoder inside soc_65xx.

---
 rtl/soc_bus_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter
// Shares the soc_65xx system bus between the CPU (master 0) and the DMA/loader
// (master 1) using round-robin arbitration. The DMA can hold the bus across
// accesses with dma_lock. Accesses that fall in the peripheral window are
// stretched until the next peripheral clock-enable pulse, and this block also
// generates that pulse.
//
// Ports
//   clk, reset_n                  system clock, async active-low reset
//   cpu_req/addr/we/do -> cpu_rdy CPU access request, completes when cpu_rdy=1
//   dma_req/lock/addr/we/do       DMA access request, plus the bus-hold flag
//   dma_ack                       DMA access completes this cycle
//   bus_addr/do/we/act            shared bus, muxed from the current owner
//   periph_en                     one-cycle peripheral enable, every DIV clocks
//   owner                         0 = none, 1 = CPU, 2 = DMA
//
// state    | meaning
// OWN_NONE | bus idle, arbitrate on the next edge
// OWN_CPU  | CPU drives the bus until cpu_rdy
// OWN_DMA  | DMA drives the bus until dma_ack
`timescale 1ns/1ps

module soc_bus_arbiter #(
    parameter int          clk_freq    = 32000000,
    parameter int          periph_freq = 4000000,
    parameter logic [15:0] periph_base = 16'hF000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_do,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic [15:0] dma_addr,
    input  logic        dma_we,
    input  logic [7:0]  dma_do,
    output logic        dma_ack,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_do,
    output logic        bus_we,
    output logic        bus_act,
    output logic        periph_en,
    output logic [1:0]  owner
);

    localparam int DIV = clk_freq / periph_freq;
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    owner_t        r_owner;
    logic          r_last_dma;   // 1: DMA was granted most recently
    logic [DW-1:0] r_div;

    owner_t        w_next;
    logic          w_hit;
    logic          w_done;
    logic          w_we;

    assign periph_en = (r_div == DIV_LAST);

    always_comb begin
        bus_addr = 16'h0000;
        bus_do   = 8'h00;
        w_we     = 1'b0;
        case (r_owner)
            OWN_CPU: begin
                bus_addr = cpu_addr;
                bus_do   = cpu_do;
                w_we     = cpu_we;
            end
            OWN_DMA: begin
                bus_addr = dma_addr;
                bus_do   = dma_do;
                w_we     = dma_we;
            end
            default: ;
        endcase
    end

    assign bus_act = (r_owner != OWN_NONE);
    assign w_hit   = (bus_addr >= periph_base);
    // Peripheral accesses only complete on the enable pulse; memory is single-cycle.
    assign w_done  = bus_act && (!w_hit || periph_en);
    assign cpu_rdy = w_done && (r_owner == OWN_CPU);
    assign dma_ack = w_done && (r_owner == OWN_DMA);
    assign bus_we  = w_done && w_we;
    assign owner   = r_owner;

    always_comb begin
        w_next = OWN_NONE;
        if (r_owner == OWN_DMA && dma_lock && dma_req) begin
            w_next = OWN_DMA;
        end else if (cpu_req && dma_req) begin
            w_next = r_last_dma ? OWN_CPU : OWN_DMA;
        end else if (cpu_req) begin
            w_next = OWN_CPU;
        end else if (dma_req) begin
            w_next = OWN_DMA;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner    <= OWN_NONE;
            r_last_dma <= 1'b1;       // CPU wins the first tie
            r_div      <= '0;
        end else begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            if (r_owner == OWN_NONE || w_done) begin
                r_owner <= w_next;
                if (w_next == OWN_CPU) begin
                    r_last_dma <= 1'b0;
                end else if (w_next == OWN_DMA) begin
                    r_last_dma <= 1'b1;
                end
            end
        end
    end

endmodule
